// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers, the muxed request
// bundle and the starvation counter width.
package dmem_arb_pkg;

    localparam int STARVE_W = 4;
    localparam int REQ_AW   = 32;

    typedef enum logic [1:0] {
        P0,
        P1,
        NONE
    } arb_port_t;

    typedef struct packed {
        logic              we;
        logic              sb;
        logic [REQ_AW-1:0] addr;
        logic [31:0]       wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the debug port was refused; force_p1
// tells the arbiter the debug port must win its next request.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAXWAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic p1_req,
    input  logic p1_gnt,
    output logic force_p1
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAXWAIT);

    logic [STARVE_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!p1_req || p1_gnt) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

    assign force_p1 = (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data-memory port (MEM stage = port 0,
// debug/loader = port 1). Define DMEM_ARB_RANGE_CHECK_EN for address/alignment checking.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH   = 10,
    parameter int MAXWAIT = 4,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_sb,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_sb,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,
    output logic          p1_err,

    output logic          mem_we,
    output logic          mem_sb,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    if (MAXWAIT < 1 || MAXWAIT > 15 || DEPTH < 1 || AW < 3 || AW > REQ_AW) begin : g_param_check
        $error("dmem_arbiter: parameter out of range");
    end

    arb_port_t winner;
    mem_req_t  win_req;
    logic      force_p1;
    logic      any_gnt;
    logic      err_c;
    logic [31:0] rdata_c;

    dmem_arb_starve_ctr #(
        .MAXWAIT (MAXWAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .p1_req   (p1_req),
        .p1_gnt   (p1_gnt),
        .force_p1 (force_p1)
    );

    // Port 0 normally wins; a starved port 1 overrides it. No grant while in reset.
    always_comb begin
        winner = NONE;
        if (reset) begin
            if (force_p1 && p1_req) begin
                winner = P1;
            end else if (p0_req) begin
                winner = P0;
            end else if (p1_req) begin
                winner = P1;
            end
        end
    end

    assign p0_gnt  = (winner == P0);
    assign p1_gnt  = (winner == P1);
    assign any_gnt = (winner != NONE);

    always_comb begin
        win_req = '0;
        case (winner)
            P0:      win_req = '{we: p0_we, sb: p0_sb, addr: REQ_AW'(p0_addr), wdata: p0_wdata};
            P1:      win_req = '{we: p1_we, sb: p1_sb, addr: REQ_AW'(p1_addr), wdata: p1_wdata};
            default: win_req = '0;
        endcase
    end

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic [REQ_AW-1:0] DEPTH_W = REQ_AW'(DEPTH);

    // Out-of-range or misaligned word accesses still complete, but never write.
    assign err_c = any_gnt &&
                   (({2'b00, win_req.addr[REQ_AW-1:2]} >= DEPTH_W) ||
                    (!win_req.sb && (win_req.addr[1:0] != 2'b00)));
`else
    assign err_c = 1'b0;
`endif

    assign rdata_c = err_c ? 32'h0 : mem_rd;

    assign mem_we = any_gnt && win_req.we && !err_c;
    assign mem_sb = win_req.sb;
    assign mem_a  = AW'(win_req.addr);
    assign mem_wd = win_req.wdata;

    // Responses land one cycle after the grant; rdata/err hold until that port's next response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
        end else begin
            p0_rvalid <= p0_gnt;
            p1_rvalid <= p1_gnt;
            if (p0_gnt) begin
                p0_rdata <= rdata_c;
                p0_err   <= err_c;
            end
            if (p1_gnt) begin
                p1_rdata <= rdata_c;
                p1_err   <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural dmem.
module tb_dmem_arbiter;

    localparam int AW      = 32;
    localparam int DEPTH   = 10;
    localparam int MAXWAIT = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        sb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tb_req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p0_sb, p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_sb, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we, mem_sb;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    int          ref_wait;
    logic [31:0] exp_rd0, exp_rd1;
    logic        exp_rv0, exp_rv1, exp_err0, exp_err1;
    int          tests = 0;
    int          fails = 0;

    dmem_arbiter #(.DEPTH(DEPTH), .MAXWAIT(MAXWAIT), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_sb     (p0_sb),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_sb     (p1_sb),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_we    (mem_we),
        .mem_sb    (mem_sb),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural dmem: combinational read, byte or word write at the clock edge.
    assign mem_rd = mem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_sb) mem[mem_a[5:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
            else        mem[mem_a[5:2]] <= mem_wd;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic bad_access(input tb_req_t r);
`ifdef DMEM_ARB_RANGE_CHECK_EN
        return ((r.addr >> 2) >= DEPTH) || (!r.sb && (r.addr % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic tb_req_t rand_req();
        tb_req_t r;
        int      word;
        r.req   = 1'b1;
        r.we    = 1'($urandom_range(0, 1));
        r.sb    = 1'($urandom_range(0, 1));
        word    = int'($urandom_range(0, 11));
        r.addr  = 32'(word * 4 + (r.sb ? int'($urandom_range(0, 3)) : 0));
        r.wdata = $urandom;
        return r;
    endfunction

    // One cycle: drive both ports, check grant/memory drive, then the responses after the edge.
    task automatic applyStimulus(input tb_req_t a, input tb_req_t b, output logic g0, output logic g1);
        logic        e0, e1, err;
        tb_req_t     w;
        logic [31:0] resp;
        int          idx;

        p0_req = a.req; p0_we = a.we; p0_sb = a.sb; p0_addr = a.addr; p0_wdata = a.wdata;
        p1_req = b.req; p1_we = b.we; p1_sb = b.sb; p1_addr = b.addr; p1_wdata = b.wdata;

        e1  = b.req && (ref_wait == MAXWAIT || !a.req);
        e0  = a.req && !e1;
        w   = e0 ? a : (e1 ? b : '0);
        err = (e0 || e1) && bad_access(w);

        #2;
        checkOutput("p0_gnt", 32'(p0_gnt), 32'(e0));
        checkOutput("p1_gnt", 32'(p1_gnt), 32'(e1));
        checkOutput("mem_we", 32'(mem_we), 32'((e0 || e1) && w.we && !err));
        checkOutput("mem_a",  mem_a, w.addr);
        checkOutput("mem_wd", mem_wd, w.wdata);

        @(posedge clk);
        #1;
        if (e0 || e1) begin
            idx  = int'(w.addr >> 2) % 16;
            resp = err ? 32'h0 : ref_mem[idx];
            if (w.we && !err) begin
                if (w.sb) ref_mem[idx][8*(w.addr % 4) +: 8] = w.wdata[7:0];
                else      ref_mem[idx] = w.wdata;
            end
            if (e0) begin exp_rd0 = resp; exp_err0 = err; end
            else    begin exp_rd1 = resp; exp_err1 = err; end
        end
        exp_rv0 = e0;
        exp_rv1 = e1;
        if (b.req && !e1) ref_wait = (ref_wait < MAXWAIT) ? ref_wait + 1 : MAXWAIT;
        else              ref_wait = 0;

        checkOutput("p0_rvalid", 32'(p0_rvalid), 32'(exp_rv0));
        checkOutput("p1_rvalid", 32'(p1_rvalid), 32'(exp_rv1));
        checkOutput("p0_rdata",  p0_rdata, exp_rd0);
        checkOutput("p1_rdata",  p1_rdata, exp_rd1);
        checkOutput("p0_err",    32'(p0_err), 32'(exp_err0));
        checkOutput("p1_err",    32'(p1_err), 32'(exp_err1));
        checkOutput("starve_cnt", 32'(dut.u_starve.cnt), 32'(ref_wait));
        g0 = e0;
        g1 = e1;
    endtask

    task automatic model_reset();
        ref_wait = 0;
        exp_rv0 = 0; exp_rv1 = 0;
        exp_rd0 = 0; exp_rd1 = 0;
        exp_err0 = 0; exp_err1 = 0;
    endtask

    initial begin
        tb_req_t idle, r0, r1, q0, q1;
        logic    g0, g1;

        idle = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[2]     = 32'hDEADBEEF;
        ref_mem[2] = 32'hDEADBEEF;
        model_reset();

        reset = 1'b0;
        {p0_req, p0_we, p0_sb, p0_addr, p0_wdata} = '0;
        {p1_req, p1_we, p1_sb, p1_addr, p1_wdata} = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
        checkOutput("rst_p1_rdata",  p1_rdata, 32'h0);
        checkOutput("rst_starve",    32'(dut.u_starve.cnt), 32'h0);
        reset = 1'b1;

        // Single read from port 0
        r0 = '{req: 1'b1, we: 1'b0, sb: 1'b0, addr: 32'h8, wdata: 32'h0};
        applyStimulus(r0, idle, g0, g1);
        checkOutput("t1_rdata", p0_rdata, 32'hDEADBEEF);

        // Port 1 word write, read back, byte store, read back
        r1 = '{req: 1'b1, we: 1'b1, sb: 1'b0, addr: 32'h4, wdata: 32'h12345678};
        applyStimulus(idle, r1, g0, g1);
        r1.we = 1'b0;
        applyStimulus(idle, r1, g0, g1);
        checkOutput("t2_read", p1_rdata, 32'h12345678);
        r1 = '{req: 1'b1, we: 1'b1, sb: 1'b1, addr: 32'h4, wdata: 32'h000000AB};
        applyStimulus(idle, r1, g0, g1);
        r1 = '{req: 1'b1, we: 1'b0, sb: 1'b0, addr: 32'h4, wdata: 32'h0};
        applyStimulus(idle, r1, g0, g1);
        checkOutput("t2_byte", p1_rdata, 32'h123456AB);

        // Both ports held: starvation guard hands port 1 the fifth cycle
        r0 = '{req: 1'b1, we: 1'b0, sb: 1'b0, addr: 32'h0, wdata: 32'h0};
        r1 = '{req: 1'b1, we: 1'b0, sb: 1'b0, addr: 32'hC, wdata: 32'h0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(r0, r1, g0, g1);
            checkOutput("t3_p1_win", 32'(g1), 32'(i == 4));
        end

        // Reset asserted mid-cycle during a port 0 write grant
        r0 = '{req: 1'b1, we: 1'b1, sb: 1'b0, addr: 32'h10, wdata: 32'h55AA55AA};
        applyStimulus(r0, r1, g0, g1);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'h55AA55AA;
        #2;
        checkOutput("t4_gnt_before", 32'(p0_gnt), 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("t4_gnt_during", 32'(p0_gnt), 32'h0);
        checkOutput("t4_we_during",  32'(mem_we), 32'h0);
        checkOutput("t4_rvalid",     32'(p0_rvalid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0;
        model_reset();
        checkOutput("t4_mem", mem[4], ref_mem[4]);
        checkOutput("t4_starve", 32'(dut.u_starve.cnt), 32'h0);

        // Word 10 is just past the end of memory
        r0 = '{req: 1'b1, we: 1'b1, sb: 1'b0, addr: 32'h28, wdata: 32'hCAFEF00D};
        applyStimulus(r0, idle, g0, g1);

        // Idle
        for (int i = 0; i < 10; i++) applyStimulus(idle, idle, g0, g1);

        // Random traffic under the hold-until-granted contract
        q0 = '0;
        q1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!q0.req && $urandom_range(0, 2) != 0) q0 = rand_req();
            if (!q1.req && $urandom_range(0, 1) != 0) q1 = rand_req();
            applyStimulus(q0, q1, g0, g1);
            if (g0) q0.req = 1'b0;
            if (g1) q1.req = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
